// File: rtl/axis_audio_pkg.sv
// -----------------------------------------------------------------------------
// axis_audio_pkg
// Shared constants and arithmetic helpers for the AXI-Stream audio blocks
// (gain stage now, mixer/EQ later).
//
// Contents:
//   DEFAULT_SAMPLE_WIDTH / DEFAULT_GAIN_WIDTH : default sample and gain widths
//   sat_result_t                               : rounded value + clip flag
//   gain_unity(gain_width)                     : unity code for Q2.(gain_width-2)
//   sat_round(product, frac_bits, out_width)   : round-half-up, then saturate
// -----------------------------------------------------------------------------
package axis_audio_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 24;
    localparam int DEFAULT_GAIN_WIDTH   = 16;

    // The value field is wide enough for any product we build here
    // (sample + gain + sign bit stays well below 64 bits).
    typedef struct packed {
        logic [63:0] value;
        logic        clip;
    } sat_result_t;

    function automatic int gain_unity(input int gain_width);
        return 1 << (gain_width - 2);
    endfunction

    // Adds half an LSB of the output scale before the arithmetic shift so
    // that ties round toward +infinity, then clamps to the signed range of
    // out_width bits. clip reports whether the clamp was needed.
    function automatic sat_result_t sat_round(
        input logic signed [63:0] product,
        input int                 frac_bits,
        input int                 out_width
    );
        sat_result_t       res;
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = (product + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_width - 1));
        res.value = rounded;
        res.clip  = 1'b0;
        if (rounded > max_v) begin
            res.value = max_v;
            res.clip  = 1'b1;
        end else if (rounded < min_v) begin
            res.value = min_v;
            res.clip  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gain_slew_ctrl.sv
// -----------------------------------------------------------------------------
// gain_slew_ctrl
// Holds the gain currently applied by the gain stage and moves it toward the
// effective target (0 while muted) once per accepted beat.
//
// Build option GAIN_SOFT_RAMP_EN:
//   defined   : gain moves at most RAMP_STEP per beat, snapping onto the
//               target once within one step.
//   undefined : gain loads the effective target directly on every beat.
//
// Ports:
//   clk           system clock
//   resetn        synchronous active-low reset, gain returns to 0
//   advance       one accepted input beat this cycle
//   gain_target   requested gain, Q2.(GAIN_WIDTH-2)
//   mute          forces the effective target to 0
//   gain_current  gain the datapath applies to the beat being accepted
// -----------------------------------------------------------------------------
module gain_slew_ctrl #(
    parameter int GAIN_WIDTH = 16,
    parameter int RAMP_STEP  = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  advance,
    input  logic [GAIN_WIDTH-1:0] gain_target,
    input  logic                  mute,
    output logic [GAIN_WIDTH-1:0] gain_current
);

    logic [GAIN_WIDTH-1:0] r_gain;
    logic [GAIN_WIDTH-1:0] w_eff;
    logic [GAIN_WIDTH-1:0] w_next;

    assign w_eff = mute ? '0 : gain_target;

`ifdef GAIN_SOFT_RAMP_EN
    localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);

    logic                  w_up;
    logic [GAIN_WIDTH-1:0] w_dist;

    // Distance is taken as an unsigned magnitude so the step never
    // overshoots the target and the sum/difference below cannot wrap.
    assign w_up   = (w_eff > r_gain);
    assign w_dist = w_up ? (w_eff - r_gain) : (r_gain - w_eff);
    assign w_next = (w_dist <= STEP) ? w_eff
                  : (w_up ? (r_gain + STEP) : (r_gain - STEP));
`else
    assign w_next = w_eff;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_gain <= '0;
        end else if (advance) begin
            r_gain <= w_next;
        end
    end

    assign gain_current = r_gain;

endmodule

// File: rtl/axis_gain_ramp.sv
// -----------------------------------------------------------------------------
// axis_gain_ramp
// AXI-Stream gain stage for NUM_CHANNELS packed signed samples per beat.
// Each channel is multiplied by an unsigned Q2.(GAIN_WIDTH-2) gain, rounded
// half-up, saturated, and reported through a sticky clip flag. The gain
// follows its target once per accepted beat (see gain_slew_ctrl).
//
// Build option GAIN_SOFT_RAMP_EN selects the slewed gain; without it the gain
// tracks the target directly and RAMP_STEP has no effect.
//
// Pipeline: S1 registers products + tlast, S2 registers the rounded,
// saturated result and drives m_axis. Latency 2, one beat per cycle.
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   gain_target       requested gain (quasi-static)
//   mute              ramp toward gain 0
//   clip_clr          clears clip_sticky (a clip in the same cycle wins)
//   s_axis_*          input stream (tdata, tvalid, tready, tlast)
//   m_axis_*          output stream (tdata, tvalid, tready, tlast)
//   gain_current      gain applied to the next accepted beat
//   clip_sticky       a channel saturated since the last clear
// -----------------------------------------------------------------------------
module axis_gain_ramp
    import axis_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int NUM_CHANNELS = 2,
    parameter int GAIN_WIDTH   = DEFAULT_GAIN_WIDTH,
    parameter int RAMP_STEP    = 256,
    localparam int DATA_WIDTH  = NUM_CHANNELS * SAMPLE_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [GAIN_WIDTH-1:0] gain_target,
    input  logic                  mute,
    input  logic                  clip_clr,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [GAIN_WIDTH-1:0] gain_current,
    output logic                  clip_sticky
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int FRAC_BITS  = GAIN_WIDTH - 2;

    logic                  w_en;
    logic                  w_advance;
    logic [GAIN_WIDTH-1:0] w_gain;
    logic [NUM_CHANNELS-1:0] w_clip;
    logic                  w_clip_any;

    logic signed [SAMPLE_WIDTH-1:0] w_samp [NUM_CHANNELS];
    logic signed [PROD_WIDTH-1:0]   w_prod [NUM_CHANNELS];
    sat_result_t                    w_res  [NUM_CHANNELS];

    logic                           r_s1_valid;
    logic                           r_s1_last;
    logic signed [PROD_WIDTH-1:0]   r_s1_prod [NUM_CHANNELS];
    logic                           r_s2_valid;
    logic                           r_s2_last;
    logic [SAMPLE_WIDTH-1:0]        r_s2_samp [NUM_CHANNELS];
    logic                           r_clip;

    // The whole pipe moves as one; a stalled output freezes both stages.
    assign w_en          = !r_s2_valid || m_axis_tready;
    assign s_axis_tready = w_en;
    assign w_advance     = s_axis_tvalid && w_en;

    gain_slew_ctrl #(
        .GAIN_WIDTH (GAIN_WIDTH),
        .RAMP_STEP  (RAMP_STEP)
    ) u_slew (
        .clk          (clk),
        .resetn       (resetn),
        .advance      (w_advance),
        .gain_target  (gain_target),
        .mute         (mute),
        .gain_current (w_gain)
    );

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign w_samp[gi] = s_axis_tdata[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            // Gain gets a leading 0 so it multiplies as a non-negative value.
            assign w_prod[gi] = PROD_WIDTH'(w_samp[gi])
                              * PROD_WIDTH'($signed({1'b0, w_gain}));
            assign w_res[gi]  = sat_round(64'(r_s1_prod[gi]), FRAC_BITS, SAMPLE_WIDTH);
            assign w_clip[gi] = w_res[gi].clip;
            assign m_axis_tdata[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_s2_samp[gi];
        end
    endgenerate

    assign w_clip_any = |w_clip;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_clip     <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_s1_prod[c] <= '0;
                r_s2_samp[c] <= '0;
            end
        end else begin
            if (w_en) begin
                r_s1_valid <= s_axis_tvalid;
                r_s1_last  <= s_axis_tlast;
                r_s2_valid <= r_s1_valid;
                r_s2_last  <= r_s1_last;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_s1_prod[c] <= w_prod[c];
                    r_s2_samp[c] <= SAMPLE_WIDTH'(w_res[c].value);
                end
            end
            // Only a real beat moving into S2 may flag a clip; a new clip
            // takes priority over a simultaneous clear.
            if (w_en && r_s1_valid && w_clip_any) begin
                r_clip <= 1'b1;
            end else if (clip_clr) begin
                r_clip <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_s2_valid;
    assign m_axis_tlast  = r_s2_last;
    assign gain_current  = w_gain;
    assign clip_sticky   = r_clip;

endmodule

// File: tb/tb_axis_gain_ramp.sv
module tb_axis_gain_ramp;

    localparam int SW = 24;
    localparam int DW = 48;

`ifdef GAIN_SOFT_RAMP_EN
    localparam logic [47:0] EXP_K1        = 48'h004000_004000;
    localparam logic [47:0] EXP_K32       = 48'h080000_080000;
    localparam logic [15:0] EXP_G_UNMUTE  = 16'h0A00;
    localparam logic [15:0] EXP_G_REVERSE = 16'h0800;
    localparam logic [15:0] EXP_G_POSTRST = 16'h0100;
`else
    localparam logic [47:0] EXP_K1        = 48'h100000_100000;
    localparam logic [47:0] EXP_K32       = 48'h100000_100000;
    localparam logic [15:0] EXP_G_UNMUTE  = 16'h4000;
    localparam logic [15:0] EXP_G_REVERSE = 16'h0000;
    localparam logic [15:0] EXP_G_POSTRST = 16'h5000;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic [15:0]   gain_target;
    logic          mute;
    logic          clip_clr;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [15:0]   gain_current;
    logic          clip_sticky;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            n_out  = 0;
    int            m_gain = 0;
    logic [48:0]   exp_q[$];
    logic [47:0]   out_log[$];
    logic          prev_stall = 1'b0;
    logic [48:0]   prev_out;

    always #5 clk = ~clk;

    axis_gain_ramp dut (
        .clk           (clk),
        .resetn        (resetn),
        .gain_target   (gain_target),
        .mute          (mute),
        .clip_clr      (clip_clr),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .gain_current  (gain_current),
        .clip_sticky   (clip_sticky)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: exact integer product, half-up rounding, clamp.
    function automatic logic [47:0] model_out(input logic [47:0] d, input int g);
        logic [47:0] res;
        longint      s;
        longint      r;
        for (int c = 0; c < 2; c++) begin
            s = longint'($signed(d[c*SW +: SW]));
            r = (s * longint'(g) + 64'sd8192) >>> 14;
            if (r > 64'sd8388607)  r = 64'sd8388607;
            if (r < -64'sd8388608) r = -64'sd8388608;
            res[c*SW +: SW] = r[23:0];
        end
        return res;
    endfunction

    function automatic int next_gain(input int g, input int tgt, input logic mu);
        int e;
        e = mu ? 0 : tgt;
`ifdef GAIN_SOFT_RAMP_EN
        if (e > g + 256) return g + 256;
        if (e < g - 256) return g - 256;
        return e;
`else
        return e;
`endif
    endfunction

    // Called at posedge+1: drive inputs, sample outputs at the negedge,
    // then return at the next posedge+1.
    task automatic step(input logic v, input logic [47:0] d, input logic l,
                        input logic rdy, input logic clr, output logic acc);
        logic [48:0] e;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = rdy;
        clip_clr = clr;
        @(negedge clk);
        check("tready_rule", 64'(s_tready), 64'(!(m_tvalid && !m_tready)));
        if (prev_stall)
            check("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, prev_out}));
        if (m_tvalid && m_tready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_beat", 64'({m_tlast, m_tdata}), 64'(e));
            end
            out_log.push_back(m_tdata);
            $display("beat %0d: data=%h last=%b gain=%h", n_out, m_tdata, m_tlast, gain_current);
            n_out++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tlast, m_tdata};
        acc = v && s_tready;
        if (acc) begin
            exp_q.push_back({l, model_out(d, m_gain)});
            m_gain = next_gain(m_gain, int'(gain_target), mute);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [47:0] d);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic        v;
        logic        l;
        logic [47:0] d;
        int          base;
        int          sent;
        int          cyc;

        // Reset
        resetn      = 1'b0;
        gain_target = 16'h4000;
        mute        = 1'b0;
        clip_clr    = 1'b0;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tlast     = 1'b0;
        m_tready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        check("rst_gain", 64'(gain_current), 64'd0);
        check("rst_clip", 64'(clip_sticky), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check("idle_gain_hold", 64'(gain_current), 64'd0);

        // Ramp-up from silence
        base = out_log.size();
        send_n(70, 48'h100000_100000);
        drain();
        check("ramp_count", 64'(out_log.size()), 64'(base + 70));
        check("ramp_k0", 64'(out_log[base]), 64'd0);
        check("ramp_k1", 64'(out_log[base + 1]), 64'(EXP_K1));
        check("ramp_k32", 64'(out_log[base + 32]), 64'(EXP_K32));
        check("ramp_k64", 64'(out_log[base + 64]), 64'h100000_100000);
        check("ramp_gain", 64'(gain_current), 64'h4000);

        // Unity and rounding
        send_n(1, 48'h123456_123456);
        drain();
        check("unity", 64'(out_log[out_log.size() - 1]), 64'h123456_123456);
        gain_target = 16'h2000;
        send_n(40, '0);
        check("half_gain", 64'(gain_current), 64'h2000);
        send_n(1, 48'h000003_FFFFFD);
        drain();
        check("round_pm3", 64'(out_log[out_log.size() - 1]), 64'h000002_FFFFFF);

        // Saturation and sticky clip
        gain_target = 16'h8000;
        send_n(100, '0);
        check("sat_gain", 64'(gain_current), 64'h8000);
        check("clip_before", 64'(clip_sticky), 64'd0);
        send_n(1, 48'hA00000_500000);
        drain();
        check("sat_out", 64'(out_log[out_log.size() - 1]), 64'h800000_7FFFFF);
        check("clip_set", 64'(clip_sticky), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
        check("clip_clr", 64'(clip_sticky), 64'd0);
        step(1'b1, 48'hA00000_500000, 1'b0, 1'b1, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check("clip_set_wins", 64'(clip_sticky), 64'd1);
        drain();

        // Mute fall, hold at zero, reversal
        gain_target = 16'h4000;
        send_n(70, '0);
        check("mute_start_gain", 64'(gain_current), 64'h4000);
        mute = 1'b1;
        send_n(64, 48'h100000_100000);
        check("mute_gain_zero", 64'(gain_current), 64'd0);
        send_n(4, 48'h100000_100000);
        drain();
        check("mute_out_zero", 64'(out_log[out_log.size() - 1]), 64'd0);
        mute = 1'b0;
        send_n(10, 48'h100000_100000);
        check("unmute_gain", 64'(gain_current), 64'(EXP_G_UNMUTE));
        mute = 1'b1;
        send_n(2, 48'h100000_100000);
        check("mute_reverse", 64'(gain_current), 64'(EXP_G_REVERSE));
        mute = 1'b0;
        drain();

        // Random backpressure, tlast every 8th beat
        gain_target = 16'h5000;
        send_n(80, '0);
        drain();
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        d    = '0;
        l    = 1'b0;
        while (sent < 1000 && cyc < 8000) begin
            if (!pend) begin
                v    = ($urandom_range(0, 3) != 0);
                d    = {24'($urandom), 24'($urandom)};
                l    = ((sent % 8) == 7);
                pend = v;
            end else begin
                v = 1'b1;
            end
            step(v, d, l, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        check("bp_all_sent", 64'(sent), 64'd1000);
        drain();
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full and the output stalled
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
        check("pre_rst_clip_clr", 64'(clip_sticky), 64'd0);
        step(1'b1, 48'h7FFFFF_7FFFFF, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 48'h100000_100000, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        check("full_tvalid", 64'(m_tvalid), 64'd1);
        check("full_clip", 64'(clip_sticky), 64'd1);
        s_tvalid = 1'b0;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_gain", 64'(gain_current), 64'd0);
        check("mid_rst_clip", 64'(clip_sticky), 64'd0);
        exp_q.delete();
        m_gain     = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 48'h100000_100000, 1'b0, 1'b1, 1'b0, acc);
        drain();
        check("post_rst_out", 64'(out_log[out_log.size() - 1]), 64'd0);
        check("post_rst_gain", 64'(gain_current), 64'(EXP_G_POSTRST));
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_gain_ramp.md
Name: axis_gain_ramp

Overview:
- Parametrised AXI-Stream gain stage, N channels × S-bit signed samples packed in one beat.
- Fine-grained fixed-point gain replaces coarse shift levels.
- Gain slews toward its target once per frame for zipper-free changes; adds mute, rounding and saturation with clip status.
- Sits between the I2S receiver stream and the I2S transmitter stream, in place of the switch-driven volume stage.

Parameters:
- SAMPLE_WIDTH, 24: signed bits per channel sample.
- NUM_CHANNELS, 2: channels per beat; channel c occupies tdata[c*SAMPLE_WIDTH +: SAMPLE_WIDTH], channel 0 = left at the LSBs.
- GAIN_WIDTH, 16: unsigned gain in Q2.(GAIN_WIDTH-2); unity = 2^(GAIN_WIDTH-2) (0x4000 at default).
- RAMP_STEP, 256: maximum gain change per accepted beat.
- Derived localparam DATA_WIDTH = NUM_CHANNELS*SAMPLE_WIDTH.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset: synchronous, active-low.
- gain_target  in  GAIN_WIDTH  requested gain; quasi-static, already synchronised.
- mute  in  1  forces effective target to 0; ramped.
- clip_clr  in  1  clears clip_sticky.
- s_axis_tdata  in  DATA_WIDTH  input frame.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input last.
- m_axis_tdata  out  DATA_WIDTH  output frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  output last.
- gain_current  out  GAIN_WIDTH  gain being applied.
- clip_sticky  out  1  set when any channel saturated since last clear.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Stage valids, m_axis_tvalid, m_axis_tlast, m_axis_tdata, clip_sticky and gain_current all go to 0.
  - Starting at gain 0 makes the block ramp up from silence after reset.
  - In-flight beats are discarded.
- Pipeline:
  - Two register stages. S1 registers the per-channel products and tlast. S2 registers the rounded, saturated result and drives the m_axis outputs.
  - Latency is 2 cycles from acceptance to m_axis_tvalid.
  - Throughput is 1 beat/cycle.
- Handshake:
  - en = !m_axis_tvalid || m_axis_tready; s_axis_tready = en.
  - Both stages and their valid bits advance only when en=1.
  - When en=0, all stage contents hold, so m_axis_tdata/tlast stay stable while tvalid is high and unaccepted.
  - No beat is lost, duplicated or reordered. tlast travels with its beat.
- Gain ramp:
  - eff_target = mute ? 0 : gain_target.
  - On each accepted input beat, the beat uses the pre-update gain_current.
  - Then, if |eff_target - gain_current| <= RAMP_STEP, gain_current = eff_target; otherwise gain_current moves RAMP_STEP toward eff_target.
  - The ramp does not update without accepted beats.
- Arithmetic, per channel:
  - p = sample (signed S) × {1'b0, gain}, signed S+GAIN_WIDTH+1 bits.
  - r = (p + 2^(GAIN_WIDTH-3)) >>> (GAIN_WIDTH-2), i.e. round-half-up.
  - Saturate r to [-2^(S-1), 2^(S-1)-1].
  - Gain 0 gives an exact 0 output.
- Clip:
  - Any channel saturating in S2 on an advancing cycle sets clip_sticky.
  - If clip_clr and a new clip occur in the same cycle, set wins.
- Boundaries:
  - Gain values up to 0xFFFF (about 4×) are legal.
  - Mute asserted mid-ramp reverses the ramp direction from the current value.
  - resetn low while m_axis_tvalid=1 drops tvalid on the next edge without waiting for tready.

Optional Feature:
- GAIN_SOFT_RAMP_EN defined: ramp behaves as described above.
- Undefined: gain_current loads eff_target directly on every accepted beat. RAMP_STEP is ignored and the ramp logic is not built. Pipeline, rounding and saturation are unchanged.

Decomposition:
- Package axis_audio_pkg holds:
  - default SAMPLE_WIDTH and GAIN_WIDTH constants;
  - function gain_unity(GAIN_WIDTH);
  - function sat_round(product, frac_bits, out_width), shared with future mixer/EQ blocks.
- Sub-module gain_slew_ctrl holds the gain_current register, step/snap compare and mute select. It takes an advance strobe (s_axis_tvalid && s_axis_tready).
- Per-channel datapath is a generate loop in the top.

Test Plan:
- Ramp-up: reset, target 0x4000, step 0x100, continuous input 0x100000 → beat k output = 0x100000 × k/64 (beat 0 → 0), gain_current = 0x4000 after 64 beats, all later outputs 0x100000.
- Unity/rounding: gain settled 0x4000 → 0x123456 passes unchanged; gain 0x2000 → -3 (0xFFFFFD) outputs -1 (0xFFFFFF), 3 outputs 2.
- Saturation: gain 0x8000, left 0x500000 / right 0xA00000 → 0x7FFFFF / 0x800000, clip_sticky=1; clip_clr → 0; clip_clr coincident with a new clip → stays 1.
- Backpressure: random m_axis_tready (~50%) over 1000 beats with tlast every 8th → output sequence and tlast positions match the model; tdata stable while stalled; tready low exactly when m_axis_tvalid && !m_axis_tready.
- Mute: at settled 0x4000 assert mute → gain falls 0x100/beat to 0 in 64 beats, outputs exactly 0 after; deassert mid-fall → reverses toward 0x4000.
- Reset mid-stream: resetn low for 1 cycle with both stages full → m_axis_tvalid=0 next cycle, gain_current=0, clip_sticky=0, next accepted beat outputs 0.
